// File: rtl/vec_pkg.sv
// Shared vector datapath types: lane/vector typing for the vector load unit
// and the vector ALU operand paths.
package vec_pkg;

    localparam int N  = 20;           // lane / memory word width
    localparam int V  = 8;            // lanes per vector
    localparam int AW = 20;           // memory address width
    localparam int LW = $clog2(V);    // lane index width

    typedef logic [N-1:0]         lane_t;
    typedef logic [V-1:0][N-1:0]  vec_t;
    typedef logic [AW-1:0]        addr_t;

    typedef enum logic [1:0] {
        VL_IDLE,
        VL_ISSUE,
        VL_LAST
    } vload_state_t;

endpackage

// File: rtl/vec_load_unit.sv
// Vector load unit: gathers V words from the scalar data memory at
// base + i*stride and presents them as one V-lane vector with a done pulse.
//
// Handshake: start is sampled only while busy=0 (IDLE, including the done
// cycle); an accepted start latches base_addr/stride, busy rises the next
// cycle and stays high until the last lane is captured; done pulses for one
// cycle with the new vec_out. start while busy=1 is dropped, never queued.
module vec_load_unit
    import vec_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW-1:0]        stride,
    output logic                 busy,
    output logic                 done,
    output logic [V-1:0][N-1:0]  vec_out,
    output logic                 mem_rd_en,
    output logic [AW-1:0]        mem_addr,
    input  logic [N-1:0]         mem_rdata
);

    vload_state_t   state;
    vload_state_t   state_nxt;
    logic [LW-1:0]  lane_idx;
    addr_t          stride_q;
    vec_t           lane_buf;
    vec_t           last_vec;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= VL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one ISSUE cycle per lane, then a single LAST cycle
    // to catch the final read's data.
    always_comb begin
        state_nxt = state;
        unique case (state)
            VL_IDLE:  if (start) state_nxt = VL_ISSUE;
            VL_ISSUE: if (lane_idx == LW'(V - 1)) state_nxt = VL_LAST;
            VL_LAST:  state_nxt = VL_IDLE;
            default:  state_nxt = VL_IDLE;
        endcase
    end

    assign busy      = (state != VL_IDLE);
    assign mem_rd_en = (state == VL_ISSUE);

    // Final vector: buffered lanes 0..V-2 plus the word arriving in LAST.
    always_comb begin
        last_vec        = lane_buf;
        last_vec[V - 1] = mem_rdata;
    end

    // Address generator, lane counter, capture buffer and output vector.
    // Read data trails the address by one cycle, so in the ISSUE cycle for
    // lane i the bus carries lane i-1's word.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr <= '0;
            stride_q <= '0;
            lane_idx <= '0;
            lane_buf <= '0;
            vec_out  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                VL_IDLE: begin
                    if (start) begin
                        mem_addr <= base_addr;
                        stride_q <= stride;
                        lane_idx <= '0;
                    end
                end
                VL_ISSUE: begin
                    if (lane_idx != '0) begin
                        lane_buf[lane_idx - LW'(1)] <= mem_rdata;
                    end
                    // Hold the last address once lane V-1 has been issued.
                    if (lane_idx != LW'(V - 1)) begin
                        mem_addr <= mem_addr + stride_q;
                        lane_idx <= lane_idx + LW'(1);
                    end
                end
                VL_LAST: begin
                    vec_out  <= last_vec;
                    done     <= 1'b1;
                    lane_idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_load_unit.sv
// Directed bench for vec_load_unit with a registered data memory model.
module tb_vec_load_unit;
  import vec_pkg::*;

  localparam int VW = V * N;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW-1:0]     stride = '0;
  logic              busy;
  logic              done;
  logic [V-1:0][N-1:0] vec_out;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [N-1:0]      mem_rdata = '0;

  int n_checks = 0;
  int n_fail = 0;
  lane_t ofs = '0;
  vec_t last_vec = '0;

  vec_load_unit dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .stride(stride), .busy(busy), .done(done), .vec_out(vec_out),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  // clock
  always #5 clk = ~clk;

  // memory contents: word[k] = k + 0x100 (+ ofs for a second data set)
  function automatic lane_t word(input logic [AW-1:0] a);
    return lane_t'(a) + lane_t'(20'h100) + ofs;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input logic [AW-1:0] s, input int i);
    return b + s * AW'(i);
  endfunction

  function automatic vec_t exp_vec(input logic [AW-1:0] b, input logic [AW-1:0] s);
    vec_t v;
    for (int i = 0; i < V; i++) v[i] = word(exp_addr(b, s, i));
    return v;
  endfunction

  // registered memory: data appears the cycle after the address
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= word(mem_addr);
  end

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One load with optional ignored start pulse in the middle; returns in
  // the cycle after the done cycle.
  task automatic run_load(input logic [AW-1:0] b, input logic [AW-1:0] s, input bit pulse, input string tag);
    vec_t ev;
    ev = exp_vec(b, s);
    base_addr = b;
    stride = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < V; i++) begin
      check({tag, "_rd_en"}, VW'(mem_rd_en), VW'(1));
      check({tag, "_addr"}, VW'(mem_addr), VW'(exp_addr(b, s, i)));
      check({tag, "_busy"}, VW'(busy), VW'(1));
      check({tag, "_nodone"}, VW'(done), VW'(0));
      check({tag, "_hold"}, vec_out, last_vec);
      if (pulse && i == 3) begin
        start = 1'b1;
        base_addr = 20'hABCDE;
        stride = 20'h7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_last_rd_en"}, VW'(mem_rd_en), VW'(0));
    check({tag, "_last_addr"}, VW'(mem_addr), VW'(exp_addr(b, s, V - 1)));
    check({tag, "_last_busy"}, VW'(busy), VW'(1));
    check({tag, "_last_nodone"}, VW'(done), VW'(0));
    check({tag, "_last_hold"}, vec_out, last_vec);
    @(negedge clk);
    check({tag, "_done"}, VW'(done), VW'(1));
    check({tag, "_done_busy"}, VW'(busy), VW'(0));
    check({tag, "_vec"}, vec_out, ev);
    last_vec = ev;
    @(negedge clk);
    check({tag, "_done_pulse"}, VW'(done), VW'(0));
    check({tag, "_idle_rd_en"}, VW'(mem_rd_en), VW'(0));
    check({tag, "_vec_keep"}, vec_out, ev);
  endtask

  initial begin
    // reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", VW'(busy), VW'(0));
    check("rst_done", VW'(done), VW'(0));
    check("rst_rd_en", VW'(mem_rd_en), VW'(0));
    check("rst_addr", VW'(mem_addr), VW'(0));
    check("rst_vec", vec_out, '0);
    reset = 1'b0;
    @(negedge clk);

    // basic: base 16 stride 1 -> lanes 0x110..0x117
    run_load(20'd16, 20'd1, 1'b0, "basic");
    check("basic_lane0", VW'(vec_out[0]), VW'(20'h110));
    check("basic_lane7", VW'(vec_out[7]), VW'(20'h117));

    // strided with ignored mid-load start
    run_load(20'd0, 20'd3, 1'b1, "stride3");
    check("stride3_lane7", VW'(vec_out[7]), VW'(20'h115));

    // broadcast
    run_load(20'd5, 20'd0, 1'b0, "bcast");
    check("bcast_lane3", VW'(vec_out[3]), VW'(20'h105));

    // wrap-around
    run_load(20'hFFFFE, 20'd1, 1'b0, "wrap");
    check("wrap_lane0", VW'(vec_out[0]), VW'(20'h000FE));
    check("wrap_lane2", VW'(vec_out[2]), VW'(20'h00100));
    check("wrap_lane7", VW'(vec_out[7]), VW'(20'h00105));

    // different data: vec_out must keep the wrap vector until done
    ofs = 20'h05000;
    run_load(20'd16, 20'd1, 1'b0, "stable");
    check("stable_lane0", VW'(vec_out[0]), VW'(20'h05110));

    // back-to-back with start held high
    ofs = 20'h00000;
    base_addr = 20'd32;
    stride = 20'd2;
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      check("b2b_a_nodone", VW'(done), VW'(0));
      check("b2b_a_busy", VW'(busy), VW'(1));
      if (k <= 8) check("b2b_a_addr", VW'(mem_addr), VW'(exp_addr(20'd32, 20'd2, k - 1)));
      if (k == 3) base_addr = 20'h00777;
      @(negedge clk);
    end
    check("b2b_a_done", VW'(done), VW'(1));
    check("b2b_a_vec", vec_out, exp_vec(20'd32, 20'd2));
    last_vec = exp_vec(20'd32, 20'd2);
    base_addr = 20'd64;
    stride = 20'd1;
    @(negedge clk);
    check("b2b_b_rd_en", VW'(mem_rd_en), VW'(1));
    check("b2b_b_addr", VW'(mem_addr), VW'(20'd64));
    start = 1'b0;
    for (int k = 11; k <= 19; k++) begin
      check("b2b_b_nodone", VW'(done), VW'(0));
      check("b2b_b_hold", vec_out, last_vec);
      @(negedge clk);
    end
    check("b2b_b_done", VW'(done), VW'(1));
    check("b2b_b_vec", vec_out, exp_vec(20'd64, 20'd1));
    last_vec = exp_vec(20'd64, 20'd1);
    @(negedge clk);

    // reset in the 4th ISSUE cycle
    base_addr = 20'd40;
    stride = 20'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_pre_busy", VW'(busy), VW'(1));
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy", VW'(busy), VW'(0));
    check("mid_rd_en", VW'(mem_rd_en), VW'(0));
    check("mid_addr", VW'(mem_addr), VW'(0));
    check("mid_vec", vec_out, '0);
    check("mid_done", VW'(done), VW'(0));
    reset = 1'b0;
    last_vec = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("mid_no_done", VW'(done), VW'(0));
    end
    run_load(20'd40, 20'd1, 1'b0, "after_rst");
    check("after_rst_lane0", VW'(vec_out[0]), VW'(20'h128));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
